// File: rtl/mult_div_pkg.sv
// Shared opcode and state definitions for the multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mult_div_pkg;

   // Operation codes on OP; 110/111 are reserved and ignored.
   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   // Sequencer states.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ITER = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } md_state_e;

endpackage

// File: rtl/mult_div.sv
// Iterative mult/multu/div/divu unit owning HI/LO; also executes mthi/mtlo.
// Latency: mult/div done in cycle after E33 (start at E0); mthi/mtlo/div-by-0 done in cycle after E0.
// Backpressure: start is ignored while busy or in DONE; the pipeline stalls on busy, outputs never wait.
module mult_div
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITER + 1);
   localparam int DW = 2 * WIDTH;
   localparam logic [WIDTH-1:0] ONE_W = 1;
   localparam logic [DW-1:0]    ONE_D = 1;

   // Two's complement helpers.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   function automatic logic [DW-1:0] neg_d(input logic [DW-1:0] v);
      return ~v + ONE_D;
   endfunction

   function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
   endfunction

   md_state_e        state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   // acc holds {partial product} for mult, {remainder, quotient} for div.
   logic [DW-1:0]    acc_q, acc_d;
   // Multiplicand magnitude for mult, divisor magnitude for div.
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d_r;
   logic             rem_neg_q, rem_neg_d;
   logic             dz_q, dz_d;

   logic             sgn_op_c;
   logic             sign_xor_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [DW-1:0]    mul_step_c;
   logic [WIDTH:0]   div_trial_c;
   logic [DW-1:0]    div_step_c;
   logic [DW-1:0]    prod_fix_c;

   assign sgn_op_c   = (OP == MD_MULT) || (OP == MD_DIV);
   assign sign_xor_c = In1[WIDTH-1] ^ In2[WIDTH-1];

   // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
   assign mul_sum_c  = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q};
   assign mul_step_c = acc_q[0] ? {mul_sum_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[DW-1:1]};

   // Restoring division: trial-subtract the divisor from the shifted remainder (33 bits).
   assign div_trial_c = acc_q[DW-1:WIDTH-1] - {1'b0, opnd_q};
   assign div_step_c  = div_trial_c[WIDTH]
                      ? {acc_q[DW-2:0], 1'b0}
                      : {div_trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign prod_fix_c = neg_q ? neg_d(acc_q) : acc_q;

   // Next-state and datapath updates for the sequencer.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_d_r   = neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (OP)
                  MD_MULT, MD_MULTU: begin
                     acc_d     = {{WIDTH{1'b0}}, mag_w(In2, sgn_op_c)};
                     opnd_d    = mag_w(In1, sgn_op_c);
                     neg_d_r   = sgn_op_c & sign_xor_c;
                     rem_neg_d = 1'b0;
                     is_div_d  = 1'b0;
                     cnt_d     = '0;
                     dz_d      = 1'b0;
                     state_d   = S_ITER;
                  end
                  MD_DIV, MD_DIVU: begin
                     if (In2 == '0) begin
                        // Divide by zero skips iteration and leaves HI/LO alone.
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        acc_d     = {{WIDTH{1'b0}}, mag_w(In1, sgn_op_c)};
                        opnd_d    = mag_w(In2, sgn_op_c);
                        neg_d_r   = sgn_op_c & sign_xor_c;
                        rem_neg_d = sgn_op_c & In1[WIDTH-1];
                        is_div_d  = 1'b1;
                        cnt_d     = '0;
                        dz_d      = 1'b0;
                        state_d   = S_ITER;
                     end
                  end
                  MD_MTHI: begin
                     hi_d    = In1;
                     dz_d    = 1'b0;
                     state_d = S_DONE;
                  end
                  MD_MTLO: begin
                     lo_d    = In1;
                     dz_d    = 1'b0;
                     state_d = S_DONE;
                  end
                  default: begin
                  end
               endcase
            end
         end
         S_ITER: begin
            acc_d = is_div_q ? div_step_c : mul_step_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (is_div_q) begin
               lo_d = neg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
               hi_d = rem_neg_q ? neg_w(acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
            end else begin
               hi_d = prod_fix_c[DW-1:WIDTH];
               lo_d = prod_fix_c[WIDTH-1:0];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous reset that discards any in-flight operation.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d_r;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
      end
   end

   assign busy     = (state_q == S_ITER) || (state_q == S_FIX);
   assign done     = (state_q == S_DONE);
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: driver pushes expected HI/LO/div_zero and due cycle,
// monitor pops and compares on every done pulse.
module tb_mult_div;
   import mult_div_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  OP    = 3'b000;
   logic [31:0] In1   = '0;
   logic [31:0] In2   = '0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   mult_div #(.WIDTH(32), .ITER(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .OP       (OP),
      .In1      (In1),
      .In2      (In2),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   always @(posedge clock) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            chk("stray_done", {31'b0, done}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".hi"},       hi,                 e.hi);
            chk({e.name, ".lo"},       lo,                 e.lo);
            chk({e.name, ".div_zero"}, {31'b0, div_zero},  {31'b0, e.dz});
            chk({e.name, ".done_cyc"}, cyc,                e.due);
         end
      end
   end

   // Issue one operation, optionally re-pulse start mid-flight, and wait for done.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int lat, input int repulse, output int nb);
      exp_t e;
      bit   got;
      @(negedge clock);
      start = 1'b1; OP = op; In1 = a; In2 = b;
      e.name = nm; e.hi = eh; e.lo = el; e.dz = edz; e.due = cyc + lat;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0; OP = MD_DIVU; In1 = $urandom; In2 = $urandom;
      nb  = 0;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (busy) nb++;
         if (done) begin
            got = 1'b1;
            break;
         end
         if (i == repulse) begin
            start = 1'b1; OP = MD_DIV; In1 = 32'd100; In2 = 32'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
      end
      start = 1'b0;
      if (!got) chk({nm, ".timeout"}, {31'b0, done}, 32'd1);
   endtask

   initial begin
      int nb;
      int nd;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst.hi",       hi,                32'h0);
      chk("rst.lo",       lo,                32'h0);
      chk("rst.busy",     {31'b0, busy},     32'h0);
      chk("rst.done",     {31'b0, done},     32'h0);
      chk("rst.div_zero", {31'b0, div_zero}, 32'h0);
      reset = 1'b0;

      // Signed multiply with a negative operand; busy spans ITER + FIX
      run_op("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, -1, nb);
      chk("mult_7_m3.busy_cycles", nb, 32'd33);

      run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, -1, nb);
      run_op("div_m7_2",  MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, -1, nb);
      run_op("divu_big",  MD_DIVU,  32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 34, -1, nb);
      run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, -1, nb);

      // Moves and divide-by-zero
      run_op("mthi", MD_MTHI, 32'h1234, 32'h0, 32'h1234, 32'h8000_0000, 1'b0, 1, -1, nb);
      chk("mthi.busy_cycles", nb, 32'd0);
      run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'h1234, 32'h8000_0000, 1'b1, 1, -1, nb);
      chk("divu_by0.busy_cycles", nb, 32'd0);
      run_op("mtlo", MD_MTLO, 32'hABCD, 32'h0, 32'h1234, 32'hABCD, 1'b0, 1, -1, nb);

      // start re-pulsed while busy is ignored
      run_op("mult_3_4_repulse", MD_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 34, 4, nb);

      // Reserved OP: no done, no busy, HI/LO untouched
      @(negedge clock);
      start = 1'b1; OP = 3'b111; In1 = 32'hDEAD_BEEF; In2 = 32'd1;
      @(negedge clock);
      start = 1'b0;
      nd = 0;
      repeat (6) begin
         if (done) nd++;
         if (busy) nd++;
         @(negedge clock);
      end
      chk("reserved.no_activity", nd, 32'd0);
      chk("reserved.hi", hi, 32'h0);
      chk("reserved.lo", lo, 32'd12);

      // Reset in the middle of a divide
      start = 1'b1; OP = MD_DIV; In1 = 32'd100; In2 = 32'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(negedge clock);
      chk("midrst.was_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst.hi",   hi,            32'h0);
      chk("midrst.lo",   lo,            32'h0);
      chk("midrst.busy", {31'b0, busy}, 32'h0);
      chk("midrst.done", {31'b0, done}, 32'h0);
      reset = 1'b0;
      run_op("multu_2_3", MD_MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 34, -1, nb);

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Multi-cycle multiply/divide unit in the execute stage, beside the ALU (ula).
- Consumes the same register-file operands In1/In2 and owns the architectural HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- mfhi/mflo read the hi/lo outputs directly through the writeback mux.
- Iterative: one bit per clock; the control unit stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width. Behaviour is defined only for 32.
- ITER, WIDTH, number of iteration cycles per mult/div.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only when busy=0
- OP  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
- In1  input  32  multiplicand / dividend / mthi-mtlo source
- In2  input  32  multiplier / divisor
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse: operation complete, hi/lo final
- div_zero  output  1  valid with done: last div/divu had divisor 0
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (synchronous, active-high, any state including mid-iteration):
  - state=IDLE; hi=lo=0; busy=done=div_zero=0.
  - Partial results are discarded.
- States: IDLE, ITER, FIX, DONE.
- IDLE + start + OP in {mult,multu,div,divu}, divisor nonzero or mult:
  - Capture operand magnitudes: abs for signed ops, raw for unsigned.
  - Capture result signs and the op kind; clear the counter.
  - Go to ITER; busy=1 from the next cycle.
- mult/multu iteration: shift-add into a 64-bit accumulator, one multiplier bit per cycle.
- div/divu iteration: restoring division, one quotient bit per cycle, 33-bit trial subtract.
- ITER: counter increments each cycle; after ITER cycles go to FIX.
- FIX, one cycle, busy=1. Sign correction, then write hi/lo:
  - Product negated if sign(In1)^sign(In2) on mult.
  - Quotient negated if sign(In1)^sign(In2); remainder takes the sign of the dividend (truncating division).
  - mult: hi = product[63:32], lo = product[31:0]. div: lo = quotient, hi = remainder.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Latency, with start sampled at edge E0:
  - ITER edges are E1..E32; FIX is written at E33.
  - done=1 in the cycle after E33; hi/lo already hold the new values in that cycle.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- Divide by zero (div/divu with In2=0):
  - No iteration; hi/lo unchanged.
  - DONE state entered at E0: done=1 and div_zero=1 in the cycle after E0.
- div_zero is cleared at the next accepted start.
- mthi/mtlo: write hi (or lo) = In1 at E0, other register unchanged; done=1 in the next cycle; busy never asserted.
- Reserved OP with start: ignored; no state change, no done.
- start while busy=1 or in DONE: ignored.
  - Operands are registered at E0, so In1/In2/OP may change during busy.
- hi/lo change only at the FIX write, at an mthi/mtlo write, or on reset.

Decomposition:
- Shared package (with the ALU OP codes): MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO localparams, and state encodings.
- No sub-module needed. A single module with combinational helpers for abs/negate (two's complement) is sufficient, target ~200 lines.

Test Plan:
- mult 7 × 0xFFFFFFFD (-3) -> done in the cycle after E33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=1. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x1234, then divu 5 / 0 -> done and div_zero in the cycle after E0; hi=0x1234 unchanged. Next mtlo 0xABCD -> lo=0xABCD, div_zero=0.
- mult 3 × 4, start re-pulsed with OP=div at cycle 5 -> ignored; result hi=0, lo=12. Reserved OP 111 with start in IDLE -> no done.
- reset asserted at iteration 10 of a div -> next cycle hi=lo=0, busy=done=0, IDLE. A new multu 2 × 3 then completes normally with lo=6.
